// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and the request legality check.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ISSUE = 3'd1,
        ST_RD_DATA  = 3'd2,
        ST_WR_ISSUE = 3'd3,
        ST_RESP     = 3'd4
    } lsu_state_t;

    // Returns 1 when a request is misaligned, uses an illegal funct3, is an
    // unsigned store, or targets a word beyond the memory.
    function automatic logic lsu_req_error(input logic        we,
                                           input logic [2:0]  funct3,
                                           input logic [31:0] addr,
                                           input logic [31:0] mem_words);
        logic bad;
        bad = 1'b0;
        case (funct3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = addr[0];
            F3_W:    bad = (addr[1:0] != 2'b00);
            F3_BU:   bad = we;
            F3_HU:   bad = we | addr[0];
            default: bad = 1'b1;
        endcase
        if ({2'b00, addr[31:2]} >= mem_words) begin
            bad = 1'b1;
        end else begin
            bad = bad;
        end
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane handling between the word-wide memory and sub-word accesses:
// extract-and-extend for loads, lane merge for read-modify-write stores.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed lane and extend it according to funct3.
    always_comb begin
        case (addr_lo)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        half_s = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    load_data = {{24{byte_s[7]}}, byte_s};
            F3_H:    load_data = {{16{half_s[15]}}, half_s};
            F3_W:    load_data = rdata;
            F3_BU:   load_data = {24'h000000, byte_s};
            F3_HU:   load_data = {16'h0000, half_s};
            default: load_data = 32'h0000_0000;
        endcase
    end

    // Replace the addressed lane of the old word with the low store bytes.
    always_comb begin
        store_word = old_word;
        case (funct3)
            F3_B: begin
                case (addr_lo)
                    2'd0:    store_word[7:0]   = wdata[7:0];
                    2'd1:    store_word[15:8]  = wdata[7:0];
                    2'd2:    store_word[23:16] = wdata[7:0];
                    2'd3:    store_word[31:24] = wdata[7:0];
                    default: store_word        = old_word;
                endcase
            end
            F3_H: begin
                if (addr_lo[1]) begin
                    store_word[31:16] = wdata[15:0];
                end else begin
                    store_word[15:0] = wdata[15:0];
                end
            end
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: takes one request at a time from execute, drives the
// word-only data memory port and returns an aligned, extended result.
// Sub-word stores are done as read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_r_enable,
    output logic        mem_w_enable,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_t  state_r, state_next_s;
    logic        we_r, we_next_s;
    logic [2:0]  funct3_r, funct3_next_s;
    logic [1:0]  addr_lo_r, addr_lo_next_s;
    logic [31:0] wdata_r, wdata_next_s;
    logic [31:0] mem_addr_next_s;
    logic [31:0] wbuf_next_s;
    logic [31:0] resp_rdata_next_s;
    logic        resp_err_next_s;
    logic [31:0] load_data_s;
    logic [31:0] store_word_s;

    lsu_align u_align (
        .rdata      (mem_rdata),
        .old_word   (mem_rdata),
        .wdata      (wdata_r),
        .addr_lo    (addr_lo_r),
        .funct3     (funct3_r),
        .load_data  (load_data_s),
        .store_word (store_word_s)
    );

    // Next-state logic plus next values for the request latch, write buffer
    // and response registers; every output is registered from these.
    always_comb begin
        state_next_s      = state_r;
        we_next_s         = we_r;
        funct3_next_s     = funct3_r;
        addr_lo_next_s    = addr_lo_r;
        wdata_next_s      = wdata_r;
        mem_addr_next_s   = mem_addr;
        wbuf_next_s       = mem_wdata;
        resp_rdata_next_s = resp_rdata;
        resp_err_next_s   = resp_err;
        case (state_r)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    we_next_s       = req_we;
                    funct3_next_s   = req_funct3;
                    addr_lo_next_s  = req_addr[1:0];
                    wdata_next_s    = req_wdata;
                    mem_addr_next_s = {req_addr[31:2], 2'b00};
                    if (lsu_req_error(req_we, req_funct3, req_addr, 32'(MEM_WORDS))) begin
                        resp_rdata_next_s = 32'h0000_0000;
                        resp_err_next_s   = 1'b1;
                        state_next_s      = ST_RESP;
                    end else if (req_we && (req_funct3 == F3_W)) begin
                        wbuf_next_s  = req_wdata;
                        state_next_s = ST_WR_ISSUE;
                    end else begin
                        state_next_s = ST_RD_ISSUE;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RD_ISSUE: state_next_s = ST_RD_DATA;
            ST_RD_DATA: begin
                if (we_r) begin
                    wbuf_next_s  = store_word_s;
                    state_next_s = ST_WR_ISSUE;
                end else begin
                    resp_rdata_next_s = load_data_s;
                    resp_err_next_s   = 1'b0;
                    state_next_s      = ST_RESP;
                end
            end
            ST_WR_ISSUE: begin
                resp_rdata_next_s = 32'h0000_0000;
                resp_err_next_s   = 1'b0;
                state_next_s      = ST_RESP;
            end
            ST_RESP: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State, latch and output registers; strobes and handshake flags are
    // registered decodes of the next state so they line up with that state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            we_r         <= 1'b0;
            funct3_r     <= 3'b000;
            addr_lo_r    <= 2'b00;
            wdata_r      <= 32'h0000_0000;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_rdata   <= 32'h0000_0000;
            resp_err     <= 1'b0;
            mem_addr     <= 32'h0000_0000;
            mem_r_enable <= 1'b0;
            mem_w_enable <= 1'b0;
            mem_wdata    <= 32'h0000_0000;
        end else begin
            state_r      <= state_next_s;
            we_r         <= we_next_s;
            funct3_r     <= funct3_next_s;
            addr_lo_r    <= addr_lo_next_s;
            wdata_r      <= wdata_next_s;
            req_ready    <= (state_next_s == ST_IDLE);
            resp_valid   <= (state_next_s == ST_RESP);
            resp_rdata   <= resp_rdata_next_s;
            resp_err     <= resp_err_next_s;
            mem_addr     <= mem_addr_next_s;
            mem_r_enable <= (state_next_s == ST_RD_ISSUE);
            mem_w_enable <= (state_next_s == ST_WR_ISSUE);
            mem_wdata    <= wbuf_next_s;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a word memory model, a
// reference model and a scoreboard of expected responses.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_r_enable;
    logic        mem_w_enable;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    load_store_unit #(.MEM_WORDS(4096)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_addr     (mem_addr),
        .mem_r_enable (mem_r_enable),
        .mem_w_enable (mem_w_enable),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nrd;
        int          nwr;
        logic        we;
        logic [31:0] addr;
        logic [31:0] new_word;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem[0:4095];
    logic [31:0] ref_mem[0:4095];
    logic        pl_en;
    logic [11:0] pl_idx;
    logic [31:0] pl_val;
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          wr_total = 0;
    logic        prev_resp = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory model: registered read data, full-word writes, preload port.
    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_val;
        if (mem_r_enable) mem_rdata <= mem[mem_addr[13:2]];
        if (mem_w_enable) mem[mem_addr[13:2]] <= mem_wdata;
    end

    // Reference behaviour of one request against the shadow memory.
    function automatic exp_t model(input logic we, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] wdata);
        exp_t        e;
        logic        bad;
        logic [31:0] old;
        logic [31:0] lane;
        logic [31:0] mask;
        int          sh;
        bad = (addr[31:2] >= 30'd4096);
        if (!(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5)) bad = 1'b1;
        if (we && f3[2]) bad = 1'b1;
        if (f3[1:0] == 2'b01 && addr[0]) bad = 1'b1;
        if (f3[1:0] == 2'b10 && addr[1:0] != 2'b00) bad = 1'b1;
        e.we = we; e.addr = addr; e.err = bad; e.rdata = 32'd0; e.new_word = 32'd0;
        e.lat = 1; e.nrd = 0; e.nwr = 0;
        if (!bad) begin
            old  = ref_mem[addr[13:2]];
            sh   = 8 * int'(addr[1:0]);
            lane = old >> sh;
            if (!we) begin
                e.lat = 3; e.nrd = 1;
                case (f3)
                    3'd0:    e.rdata = {{24{lane[7]}}, lane[7:0]};
                    3'd1:    e.rdata = {{16{lane[15]}}, lane[15:0]};
                    3'd4:    e.rdata = lane & 32'h0000_00FF;
                    3'd5:    e.rdata = lane & 32'h0000_FFFF;
                    default: e.rdata = old;
                endcase
            end else begin
                mask = (f3 == 3'd0) ? 32'h0000_00FF : (f3 == 3'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
                e.new_word = (old & ~(mask << sh)) | ((wdata & mask) << sh);
                e.nwr = 1;
                e.nrd = (f3 == 3'd2) ? 0 : 1;
                e.lat = (f3 == 3'd2) ? 2 : 4;
            end
        end
        return e;
    endfunction

    // Monitor: counts strobes, scores responses, tracks accepts.
    always @(negedge clk) begin
        exp_t e;
        cyc = cyc + 1;
        if (pl_en) ref_mem[pl_idx] = pl_val;
        if (mem_r_enable) rd_cnt++;
        if (mem_w_enable) begin
            wr_cnt++;
            wr_total++;
        end
        if (mem_r_enable || mem_w_enable)
            check_val("strobe_excl", {31'd0, mem_r_enable & mem_w_enable}, 32'd0);
        if (resp_valid) begin
            check_val("resp_pulse_prev", {31'd0, prev_resp}, 32'd0);
            check_val("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_val("resp_rdata", resp_rdata, e.rdata);
                check_val("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                check_val("latency", 32'(cyc - acc_cyc), 32'(e.lat));
                check_val("read_pulses", 32'(rd_cnt), 32'(e.nrd));
                check_val("write_pulses", 32'(wr_cnt), 32'(e.nwr));
                check_val("mem_addr", mem_addr, {e.addr[31:2], 2'b00});
                if (e.we && !e.err) begin
                    ref_mem[e.addr[13:2]] = e.new_word;
                    check_val("mem_word", mem[e.addr[13:2]], e.new_word);
                end
            end
        end
        prev_resp = resp_valid;
        if (req_valid && req_ready && !rst) begin
            acc_cyc = cyc;
            rd_cnt  = 0;
            wr_cnt  = 0;
        end
    end

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output time t_acc);
        logic got;
        got = 1'b0;
        t_acc = 0;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin
                got = 1'b1;
                break;
            end
        end
        check_val("accept_wait", {31'd0, got}, 32'd1);
        if (got) begin
            sb.push_back(model(we, f3, addr, wdata));
            t_acc = $time;
        end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        check_val("drain", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic one(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
        time t;
        do_req(we, f3, addr, wdata, t);
        req_valid = 1'b0;
        drain();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        check_val({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
        check_val({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        check_val({tag, "_resp_err"}, {31'd0, resp_err}, 32'd0);
        check_val({tag, "_mem_addr"}, mem_addr, 32'd0);
        check_val({tag, "_mem_r"}, {31'd0, mem_r_enable}, 32'd0);
        check_val({tag, "_mem_w"}, {31'd0, mem_w_enable}, 32'd0);
        check_val({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        time t0, t1, t2;
        int  w0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 32'd0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0;
        pl_en = 1'b1; pl_idx = 12'h010; pl_val = 32'h8899_AABB;
        repeat (2) @(posedge clk);
        #1;
        pl_en = 1'b0;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        one(1'b0, 3'd0, 32'h41, 32'd0);           // LB  -> FFFFFFAA
        one(1'b0, 3'd4, 32'h43, 32'd0);           // LBU -> 00000088
        one(1'b0, 3'd5, 32'h42, 32'd0);           // LHU -> 00008899
        one(1'b1, 3'd0, 32'h42, 32'h1234_5677);   // SB  -> 8877AABB
        one(1'b0, 3'd2, 32'h40, 32'd0);
        one(1'b1, 3'd2, 32'h40, 32'hDEAD_BEEF);   // SW
        one(1'b0, 3'd2, 32'h40, 32'd0);
        one(1'b0, 3'd1, 32'h42, 32'd0);           // LH  -> FFFFDEAD
        one(1'b0, 3'd0, 32'h40, 32'd0);           // LB  -> FFFFFFEF
        one(1'b1, 3'd1, 32'h40, 32'h0000_1234);   // SH  -> DEAD1234
        one(1'b0, 3'd2, 32'h40, 32'd0);
        one(1'b0, 3'd1, 32'h41, 32'd0);           // misaligned LH
        one(1'b0, 3'd2, 32'h42, 32'd0);           // misaligned LW
        one(1'b1, 3'd4, 32'h40, 32'h5555_5555);   // unsigned store
        one(1'b0, 3'd2, 32'h4000, 32'd0);         // word 4096
        one(1'b0, 3'd3, 32'h40, 32'd0);           // illegal funct3
        one(1'b1, 3'd2, 32'h3FFC, 32'hCAFE_F00D); // last word
        one(1'b0, 3'd4, 32'h3FFF, 32'd0);

        // Reset during RD_DATA of an SH: no write, word unchanged.
        w0 = wr_total;
        do_req(1'b1, 3'd1, 32'h40, 32'h0000_FFFF, t0);
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("midrst_held");
        rst = 1'b0;
        sb.delete();
        repeat (3) @(posedge clk);
        #1;
        check_val("midrst_no_write", 32'(wr_total - w0), 32'd0);
        check_val("midrst_word", mem[16], ref_mem[16]);

        // Three loads with req_valid held high.
        do_req(1'b0, 3'd2, 32'h40, 32'd0, t0);
        do_req(1'b0, 3'd0, 32'h41, 32'd0, t1);
        do_req(1'b0, 3'd5, 32'h42, 32'd0, t2);
        req_valid = 1'b0;
        check_val("spacing_1", 32'((t1 - t0) / 10), 32'd4);
        check_val("spacing_2", 32'((t2 - t1) / 10), 32'd4);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator for the core's data-memory port: accepts one load or store request at a time from the execute stage, drives the word-only `memory` data port (`mem_addr`/`mem_r_enable`/`mem_w_enable`/`mem_wdata`, 1-cycle registered `mem_rdata`), and returns an aligned, extended result.

- Performs byte/halfword loads by extract-and-extend.
- Performs byte/halfword stores by read-modify-write, because the memory only writes full words.
- Sits between execute and the `memory` block.

## Interface
Parameters:
- `MEM_WORDS`, 4096: number of 32-bit words behind the port; word index ≥ `MEM_WORDS` is an error.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock
- `rst`  in  1  asynchronous active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  high only in IDLE; accept = `req_valid && req_ready` at posedge
- `req_we`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data (low bytes used for B/H)
- `resp_valid`  out  1  one-cycle completion pulse
- `resp_rdata`  out  32  load result, 0 for stores/errors
- `resp_err`  out  1  misaligned, illegal funct3, or out of range
- `mem_addr`  out  32  word-aligned address `{addr[31:2],2'b00}`
- `mem_r_enable`  out  1  read strobe
- `mem_w_enable`  out  1  write strobe (never together with `mem_r_enable`)
- `mem_wdata`  out  32  write word
- `mem_rdata`  in  32  valid the cycle after the `mem_r_enable` edge

## Operation
States: IDLE, RD_ISSUE, RD_DATA, WR_ISSUE, RESP.

- IDLE, on accept: latch `we`, `funct3`, `addr`, `wdata`, then check for errors.
  - Error conditions: H/HU with `addr[0]=1`; W with `addr[1:0]≠0`; funct3 011/110/111; store with funct3 100/101; `addr[31:2] ≥ MEM_WORDS`.
  - On error: go to RESP with `resp_err=1`, `resp_rdata=0`. No memory strobe is issued.
  - Otherwise, load or store B/H → RD_ISSUE; store W → WR_ISSUE with `wbuf=wdata`.
- RD_ISSUE: `mem_r_enable=1`, then → RD_DATA.
- RD_DATA: `mem_rdata` is valid.
  - Load: select byte lane `addr[1:0]` or halfword lane `addr[1]`; sign-extend for B/H, zero-extend for BU/HU, pass W through. Register the result into `resp_rdata`, then → RESP.
  - Store B/H: `wbuf` = `mem_rdata` with the addressed lane replaced by `wdata[7:0]` or `wdata[15:0]`, then → WR_ISSUE.
- WR_ISSUE: `mem_w_enable=1`, `mem_wdata=wbuf`, then → RESP.
- RESP: `resp_valid=1` for exactly one cycle, then → IDLE. The response has no backpressure.
- Outside the issue states: `mem_addr` holds the latched word address; strobes are 0.

## Timing
- Reset values:
  - State IDLE, so `req_ready=1`.
  - `resp_valid`, `resp_rdata`, `resp_err`, `mem_r_enable`, `mem_w_enable`, `mem_wdata`, `mem_addr` all 0.
- Latency from the accept edge to the cycle `resp_valid` is high:
  - Error: 1
  - SW: 2
  - Load: 3
  - SB/SH: 4
- Throughput:
  - `req_ready` drops the cycle after accept and returns the cycle after RESP.
  - A back-to-back request is accepted on the edge ending IDLE's first cycle.
- Reset mid-operation aborts immediately.
  - Reset before WR_ISSUE: no write reaches memory, so the target word is unchanged.
  - Reset during WR_ISSUE: the outcome depends on which edge wins. This is not checked.
- `resp_rdata`/`resp_err` hold until the next response; only `resp_valid` pulses.

## Structure
- Package `lsu_pkg`:
  - funct3 localparams (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`)
  - `typedef enum logic [2:0] lsu_state_t`
- Sub-module `lsu_align`, purely combinational:
  - load extract/extend (`rdata`, `addr[1:0]`, `funct3` → result)
  - store merge (`old`, `wdata`, `addr[1:0]`, `funct3` → word)
- Top: FSM, request latch, `wbuf`, output registers.

## Test plan
- Setup for these scenarios: word index 0x10 preloaded with 0x8899AABB.
  - LB 0x41 → `resp_rdata=0xFFFFFFAA`, 3 cycles, one `mem_r_enable` pulse.
  - LBU 0x43 → `0x00000088`.
  - LHU 0x42 → `0x00008899`.
  - SB 0x42 with wdata 0x12345677 → memory word becomes 0x8877AABB.
    - Exactly one read then one write pulse.
    - `resp_valid` 4 cycles after accept; `resp_rdata=0`.
- SW 0x40 with 0xDEADBEEF → `mem_w_enable` in the cycle after accept, no read, response at 2 cycles. A subsequent LW 0x40 returns 0xDEADBEEF.
- Error cases, each → `resp_err=1` at 1 cycle, no strobe:
  - LH 0x41
  - LW 0x42
  - store with funct3 100
  - LW 0x4000 (word 4096)
- Reset asserted during RD_DATA of SH 0x40 → no `mem_w_enable`, word unchanged, `req_ready=1` and all outputs 0 while reset is held.
- `req_valid` held high with three loads queued → accepts are spaced 4 cycles apart; each `resp_valid` is a single-cycle pulse carrying the correct data.
